// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch stage and its memory.
// Master issues rd_en/addr, slave returns rdata with an rvalid strobe.
interface fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 19
);
  logic               rd_en;
  logic [ADDR_W-1:0]  addr;
  logic [INSTR_W-1:0] rdata;
  logic               rvalid;

  modport master (
    output rd_en,
    output addr,
    input  rdata,
    input  rvalid
  );

  modport slave (
    input  rd_en,
    input  addr,
    output rdata,
    output rvalid
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC, IMEM read FSM, IR, optional return-address stack.
// Define FETCH_RAS_EN to build the hardware return-address stack.
module fetch_unit #(
  parameter int INSTR_W      = 19,
  parameter int OPCODE_W     = 5,
  parameter int ADDR_W       = 16,
  parameter int RESET_VECTOR = 0,
  parameter int RAS_DEPTH    = 8
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic                        FETCH_REQ,
  input  logic                        INC_PC,
  input  logic                        LOAD_PC,
  input  logic                        CALL_EN,
  input  logic                        RET_EN,
  input  logic [ADDR_W-1:0]           TARGET_ADDR,
  fetch_unit_if.master                im,
  output logic [INSTR_W-1:0]          IR,
  output logic [OPCODE_W-1:0]         OPCODE,
  output logic [INSTR_W-OPCODE_W-1:0] OPERAND,
  output logic                        IR_VALID,
  output logic                        FETCH_BUSY,
  output logic [ADDR_W-1:0]           PC,
  output logic                        RAS_OVF,
  output logic                        RAS_UNF
);

  localparam logic [ADDR_W-1:0] RV = ADDR_W'(RESET_VECTOR);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t state;

  assign OPCODE  = IR[INSTR_W-1 -: OPCODE_W];
  assign OPERAND = IR[INSTR_W-OPCODE_W-1:0];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      im.rd_en   <= 1'b0;
      im.addr    <= '0;
      IR         <= '0;
      IR_VALID   <= 1'b0;
      FETCH_BUSY <= 1'b0;
    end else begin
      IR_VALID <= 1'b0;
      unique case (state)
        IDLE: begin
          if (FETCH_REQ) begin
            state      <= REQ;
            im.rd_en   <= 1'b1;
            im.addr    <= PC;
            FETCH_BUSY <= 1'b1;
          end
        end
        REQ: begin
          state <= WAIT;
        end
        WAIT: begin
          if (im.rvalid) begin
            state      <= IDLE;
            IR         <= im.rdata;
            IR_VALID   <= 1'b1;
            im.rd_en   <= 1'b0;
            FETCH_BUSY <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          im.rd_en   <= 1'b0;
          FETCH_BUSY <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_RAS_EN
  localparam int SP_W = $clog2(RAS_DEPTH) + 1;
  localparam logic [SP_W-1:0] FULL = SP_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_m1;
  logic              push;

  assign sp_m1 = sp - 1'b1;
  assign push  = CALL_EN && !RET_EN && (sp != FULL);

  // Stack storage needs no reset; sp alone defines what is live.
  always_ff @(posedge CLK) begin
    if (push) begin
      ras[sp[SP_W-2:0]] <= PC;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      PC      <= RV;
      sp      <= '0;
      RAS_OVF <= 1'b0;
      RAS_UNF <= 1'b0;
    end else if (RET_EN) begin
      if (sp != '0) begin
        PC <= ras[sp_m1[SP_W-2:0]];
        sp <= sp_m1;
      end else begin
        RAS_UNF <= 1'b1;
      end
    end else if (CALL_EN) begin
      PC <= TARGET_ADDR;
      if (sp != FULL) begin
        sp <= sp + 1'b1;
      end else begin
        RAS_OVF <= 1'b1;
      end
    end else if (LOAD_PC) begin
      PC <= TARGET_ADDR;
    end else if (INC_PC) begin
      PC <= PC + 1'b1;
    end
  end
`else
  // Without a stack, software supplies the return address on TARGET_ADDR.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      PC <= RV;
    end else if (RET_EN || CALL_EN || LOAD_PC) begin
      PC <= TARGET_ADDR;
    end else if (INC_PC) begin
      PC <= PC + 1'b1;
    end
  end

  assign RAS_OVF = 1'b0;
  assign RAS_UNF = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomised checks of fetch_unit against a behavioural model.
// Build with FETCH_RAS_EN defined to exercise the return-address stack.
module tb_fetch_unit;

  localparam int DEPTH = 8;

  logic        CLK;
  logic        RESET_N;
  logic        FETCH_REQ;
  logic        INC_PC;
  logic        LOAD_PC;
  logic        CALL_EN;
  logic        RET_EN;
  logic [15:0] TARGET_ADDR;
  logic [18:0] IR;
  logic [4:0]  OPCODE;
  logic [13:0] OPERAND;
  logic        IR_VALID;
  logic        FETCH_BUSY;
  logic [15:0] PC;
  logic        RAS_OVF;
  logic        RAS_UNF;

  fetch_unit_if #(.ADDR_W(16), .INSTR_W(19)) im ();

  fetch_unit #(
    .INSTR_W(19), .OPCODE_W(5), .ADDR_W(16),
    .RESET_VECTOR(0), .RAS_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .FETCH_REQ(FETCH_REQ),
    .INC_PC(INC_PC), .LOAD_PC(LOAD_PC), .CALL_EN(CALL_EN),
    .RET_EN(RET_EN), .TARGET_ADDR(TARGET_ADDR), .im(im.master),
    .IR(IR), .OPCODE(OPCODE), .OPERAND(OPERAND),
    .IR_VALID(IR_VALID), .FETCH_BUSY(FETCH_BUSY), .PC(PC),
    .RAS_OVF(RAS_OVF), .RAS_UNF(RAS_UNF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors;
  int miscompares;

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask

  // Model: PC rules, a queue for the stack, and a fetch tracked by age.
  logic [15:0] m_pc, m_addr, old_pc;
  logic [18:0] m_ir;
  logic        m_irv, m_busy, m_ovf, m_unf;
  int          m_age;
  logic [15:0] stk[$];

  always @(posedge CLK) begin
    if (!RESET_N) begin
      m_pc = 16'h0; m_addr = 16'h0; m_ir = 19'h0;
      m_irv = 1'b0; m_busy = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      m_age = 0;
      stk.delete();
    end else begin
      old_pc = m_pc;
      m_irv = 1'b0;
`ifdef FETCH_RAS_EN
      if (RET_EN) begin
        if (stk.size() > 0) m_pc = stk.pop_back();
        else m_unf = 1'b1;
      end else if (CALL_EN) begin
        if (stk.size() < DEPTH) stk.push_back(m_pc);
        else m_ovf = 1'b1;
        m_pc = TARGET_ADDR;
      end else if (LOAD_PC) m_pc = TARGET_ADDR;
      else if (INC_PC) m_pc = 16'((32'(m_pc) + 1) % 65536);
`else
      if (RET_EN || CALL_EN || LOAD_PC) m_pc = TARGET_ADDR;
      else if (INC_PC) m_pc = 16'((32'(m_pc) + 1) % 65536);
`endif
      if (m_busy) begin
        m_age++;
        if (m_age >= 2 && im.rvalid) begin
          m_ir = im.rdata; m_irv = 1'b1; m_busy = 1'b0;
        end
      end else if (FETCH_REQ) begin
        m_busy = 1'b1; m_age = 0; m_addr = old_pc;
      end
    end
    #1;
    chk("pc", 32'(PC), 32'(m_pc));
    chk("ir", 32'(IR), 32'(m_ir));
    chk("opcode", 32'(OPCODE), 32'(m_ir[18:14]));
    chk("operand", 32'(OPERAND), 32'(m_ir[13:0]));
    chk("ir_valid", 32'(IR_VALID), 32'(m_irv));
    chk("busy", 32'(FETCH_BUSY), 32'(m_busy));
    chk("rd_en", 32'(im.rd_en), 32'(m_busy));
    chk("im_addr", 32'(im.addr), 32'(m_addr));
    chk("ovf", 32'(RAS_OVF), 32'(m_ovf));
    chk("unf", 32'(RAS_UNF), 32'(m_unf));
  end

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic clr();
    FETCH_REQ = 0; INC_PC = 0; LOAD_PC = 0;
    CALL_EN = 0; RET_EN = 0; im.rvalid = 0;
  endtask

  task automatic cmd(string c, logic [15:0] t);
    clr();
    TARGET_ADDR = t;
    unique case (c)
      "load": LOAD_PC = 1;
      "inc":  INC_PC = 1;
      "call": CALL_EN = 1;
      "ret":  RET_EN = 1;
      default: ;
    endcase
    cyc();
    clr();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    RESET_N = 0; TARGET_ADDR = 0; im.rdata = 0;
    clr();
    cyc(); cyc();
    chk("rst_pc", 32'(PC), 32'h0);
    chk("rst_ir", 32'(IR), 32'h0);
    chk("rst_busy", 32'(FETCH_BUSY), 32'h0);
    chk("rst_rd_en", 32'(im.rd_en), 32'h0);
    RESET_N = 1;
    cyc();

    // Basic fetch with minimum latency
    FETCH_REQ = 1; cyc(); FETCH_REQ = 0;
    chk("f1_addr", 32'(im.addr), 32'h0);
    chk("f1_rd_en", 32'(im.rd_en), 32'h1);
    cyc();
    im.rvalid = 1; im.rdata = 19'h2A5F1; cyc(); im.rvalid = 0;
    chk("f1_irv", 32'(IR_VALID), 32'h1);
    chk("f1_ir", 32'(IR), 32'h2A5F1);
    chk("f1_opc", 32'(OPCODE), 32'h0A);
    chk("f1_opnd", 32'(OPERAND), 32'h25F1);
    cyc();
    chk("f1_irv_off", 32'(IR_VALID), 32'h0);
    chk("f1_idle", 32'(FETCH_BUSY), 32'h0);

    // PC wrap and priority
    cmd("load", 16'hFFFF);
    chk("pc_ffff", 32'(PC), 32'hFFFF);
    cmd("inc", 16'h0);
    chk("pc_wrap", 32'(PC), 32'h0);
    INC_PC = 1; LOAD_PC = 1; TARGET_ADDR = 16'h0100; cyc(); clr();
    chk("pc_prio", 32'(PC), 32'h0100);

    // PC change during WAIT; repeated FETCH_REQ ignored
    cmd("load", 16'h0005);
    FETCH_REQ = 1; cyc(); FETCH_REQ = 0;
    chk("f2_addr", 32'(im.addr), 32'h5);
    cyc();
    cmd("inc", 16'h0);
    chk("f2_pc", 32'(PC), 32'h6);
    chk("f2_addr_hold", 32'(im.addr), 32'h5);
    FETCH_REQ = 1; cyc(); FETCH_REQ = 0;
    im.rvalid = 1; im.rdata = 19'h12345; cyc(); im.rvalid = 0;
    chk("f2_ir", 32'(IR), 32'h12345);
    cyc();
    chk("f2_idle", 32'(FETCH_BUSY), 32'h0);

`ifdef FETCH_RAS_EN
    cmd("load", 16'h0010);
    cmd("call", 16'h0040); chk("c1", 32'(PC), 32'h40);
    cmd("call", 16'h0080); chk("c2", 32'(PC), 32'h80);
    cmd("ret", 16'h0);     chk("r1", 32'(PC), 32'h40);
    cmd("ret", 16'h0);     chk("r2", 32'(PC), 32'h10);
    for (int i = 0; i <= DEPTH; i++) cmd("call", 16'(16'h0200 + i));
    chk("ovf", 32'(RAS_OVF), 32'h1);
    chk("ovf_pc", 32'(PC), 32'(16'h0200 + DEPTH));
    for (int i = 0; i < DEPTH; i++) cmd("ret", 16'h0);
    chk("unwind_pc", 32'(PC), 32'h10);
    chk("unf_pre", 32'(RAS_UNF), 32'h0);
    cmd("ret", 16'h0);
    chk("unf", 32'(RAS_UNF), 32'h1);
    chk("unf_pc", 32'(PC), 32'h10);
`else
    cmd("call", 16'h0040); chk("c1", 32'(PC), 32'h40);
    cmd("ret", 16'h0123);  chk("r1", 32'(PC), 32'h123);
    chk("ovf_tied", 32'(RAS_OVF), 32'h0);
    chk("unf_tied", 32'(RAS_UNF), 32'h0);
`endif

    // Random mix, checked cycle by cycle against the model
    for (int i = 0; i < 300; i++) begin
      FETCH_REQ = 1'($urandom_range(0, 1));
      INC_PC = ($urandom_range(0, 3) == 0);
      LOAD_PC = ($urandom_range(0, 5) == 0);
      CALL_EN = ($urandom_range(0, 6) == 0);
      RET_EN = ($urandom_range(0, 6) == 0);
      TARGET_ADDR = 16'($urandom);
      im.rvalid = ($urandom_range(0, 2) == 0);
      im.rdata = 19'($urandom);
      cyc();
    end
    clr();
    cyc();

    // Reset in the middle of a fetch
    cmd("load", 16'h0033);
    FETCH_REQ = 1; cyc(); FETCH_REQ = 0;
    cyc();
    RESET_N = 0;
    #1;
    chk("arst_busy", 32'(FETCH_BUSY), 32'h0);
    chk("arst_rd_en", 32'(im.rd_en), 32'h0);
    cyc();
    RESET_N = 1;
    im.rvalid = 1; im.rdata = 19'h7FFFF;
    cyc(); cyc();
    im.rvalid = 0;
    chk("late_ir", 32'(IR), 32'h0);
    chk("late_irv", 32'(IR_VALID), 32'h0);
    chk("late_pc", 32'(PC), 32'h0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
